// File: rtl/psum_readout.sv
// Drain-side consumer of a systolic column's partial-sum chain: rounding shift,
// signed saturation, a one-entry stage register and a small FIFO toward the output SRAM feeder.
module psum_readout #(
    parameter int OC_W  = 16,
    parameter int OUT_W = 8,
    parameter int Y     = 8,
    parameter int DEPTH = 4,
    parameter int SH_W  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic [OC_W-1:0]        i_c,
    input  logic                   i_c_valid,
    input  logic [SH_W-1:0]        i_shift,
    input  logic                   i_clr_err,
    output logic                   o_stall,
    output logic [OUT_W-1:0]       o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last,
    output logic                   o_ovf,
    output logic                   o_drop
);

    localparam int AW    = $clog2(DEPTH);
    localparam int IDX_W = (Y > 1) ? $clog2(Y) : 1;

    localparam logic signed [OC_W:0]  SAT_MAX  = (OC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [OC_W:0]  SAT_MIN  = (OC_W+1)'(-(1 << (OUT_W-1)));
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(Y - 1);
    localparam logic [AW:0]           STALL_TH = (AW+1)'(DEPTH - 1);

    // Registered state
    logic [OUT_W-1:0] stage_data_q, stage_data_d;
    logic             stage_last_q, stage_last_d;
    logic             stage_v_q,    stage_v_d;
    logic [IDX_W-1:0] idx_q,        idx_d;
    logic [AW:0]      wptr_q,       wptr_d;
    logic [AW:0]      rptr_q,       rptr_d;
    logic             ovf_q,        ovf_d;
    logic             drop_q,       drop_d;

    logic [OUT_W-1:0] mem_data_q [DEPTH];
    logic             mem_last_q [DEPTH];

    // Requantization datapath; one extra bit keeps c + 2^(s-1) from wrapping.
    logic signed [OC_W:0] sum_ext;
    logic signed [OC_W:0] rnd;
    logic signed [OC_W:0] shifted;
    logic                 sat_hi;
    logic                 sat_lo;
    logic [OUT_W-1:0]     req_data;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sum_ext = {i_c[OC_W-1], i_c};
        rnd     = '0;
        if (i_shift != '0) begin
            rnd = (OC_W+1)'(1) << (i_shift - SH_W'(1));
        end
        shifted = (sum_ext + rnd) >>> i_shift;
        sat_hi  = shifted > SAT_MAX;
        sat_lo  = shifted < SAT_MIN;
        if (sat_hi) begin
            req_data = SAT_MAX[OUT_W-1:0];
        end else if (sat_lo) begin
            req_data = SAT_MIN[OUT_W-1:0];
        end else begin
            req_data = shifted[OUT_W-1:0];
        end
    end

    logic        fifo_empty;
    logic        fifo_full;
    logic [AW:0] fifo_count;
    logic [AW:0] occupancy;
    logic        pop;
    logic        push;
    logic        load;

    always_comb begin
        fifo_empty = (wptr_q == rptr_q);
        fifo_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        fifo_count = wptr_q - rptr_q;
        occupancy  = fifo_count + (AW+1)'(stage_v_q);
        pop        = !fifo_empty && i_ready;
        // A pop frees a slot in the same cycle, so a full FIFO still accepts the stage.
        push       = stage_v_q && (!fifo_full || pop);
        load       = i_c_valid && (!stage_v_q || push);
    end

    always_comb begin
        stage_v_d    = stage_v_q;
        stage_data_d = stage_data_q;
        stage_last_d = stage_last_q;
        idx_d        = idx_q;
        if (push) begin
            stage_v_d = 1'b0;
        end
        if (load) begin
            stage_v_d    = 1'b1;
            stage_data_d = req_data;
            stage_last_d = (idx_q == IDX_LAST);
            idx_d        = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        wptr_d = wptr_q + (AW+1)'(push);
        rptr_d = rptr_q + (AW+1)'(pop);
        // Sticky flags: a new event in the clearing cycle wins over the clear.
        ovf_d  = (ovf_q  && !i_clr_err) || (load && (sat_hi || sat_lo));
        drop_d = (drop_q && !i_clr_err) || (i_c_valid && !load);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            stage_v_q    <= 1'b0;
            stage_data_q <= '0;
            stage_last_q <= 1'b0;
            idx_q        <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            ovf_q        <= 1'b0;
            drop_q       <= 1'b0;
        end else begin
            stage_v_q    <= stage_v_d;
            stage_data_q <= stage_data_d;
            stage_last_q <= stage_last_d;
            idx_q        <= idx_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            ovf_q        <= ovf_d;
            drop_q       <= drop_d;
        end
    end

    // NOTE: the storage array is not reset; emptiness comes from the pointers and the head is gated to zero while empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data_q[wptr_q[AW-1:0]] <= stage_data_q;
            mem_last_q[wptr_q[AW-1:0]] <= stage_last_q;
        end
    end

    always_comb begin
        o_valid = !fifo_empty;
        o_data  = fifo_empty ? '0   : mem_data_q[rptr_q[AW-1:0]];
        o_last  = fifo_empty ? 1'b0 : mem_last_q[rptr_q[AW-1:0]];
        o_stall = occupancy >= STALL_TH;
        o_ovf   = ovf_q;
        o_drop  = drop_q;
    end

endmodule

// File: tb/tb_psum_readout.sv
// Scoreboard bench for psum_readout: expected outputs are queued as inputs are
// driven and compared in order as the DUT hands them downstream.
module tb_psum_readout;

    localparam int OC_W  = 16;
    localparam int OUT_W = 8;
    localparam int Y     = 8;
    localparam int DEPTH = 4;
    localparam int SH_W  = 4;

    logic               clk = 1'b0;
    logic               rstn;
    logic [OC_W-1:0]    c_in;
    logic               c_valid;
    logic [SH_W-1:0]    shift;
    logic               clr_err;
    logic               stall;
    logic [OUT_W-1:0]   data;
    logic               valid;
    logic               ready;
    logic               last;
    logic               ovf;
    logic               drop;

    psum_readout #(
        .OC_W (OC_W),
        .OUT_W(OUT_W),
        .Y    (Y),
        .DEPTH(DEPTH),
        .SH_W (SH_W)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rstn),
        .i_c      (c_in),
        .i_c_valid(c_valid),
        .i_shift  (shift),
        .i_clr_err(clr_err),
        .o_stall  (stall),
        .o_data   (data),
        .o_valid  (valid),
        .i_ready  (ready),
        .o_last   (last),
        .o_ovf    (ovf),
        .o_drop   (drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
    } exp_t;

    exp_t exp_q[$];
    int   pop_cyc[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   idx_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference requantizer in plain integer arithmetic.
    function automatic logic [OUT_W-1:0] model(input logic [OC_W-1:0] c, input int s);
        int v;
        int r;
        v = int'($signed(c));
        if (s > 0) v = v + (1 << (s - 1));
        r = v >>> s;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r[OUT_W-1:0];
    endfunction

    task automatic expect_push(input logic [OUT_W-1:0] d);
        exp_t e;
        e.d = d;
        e.l = (idx_m == Y - 1);
        exp_q.push_back(e);
        idx_m = (idx_m == Y - 1) ? 0 : idx_m + 1;
    endtask

    // Drives one input for one cycle; entered and left at posedge+1.
    task automatic send(input logic [OC_W-1:0] c, input logic [OUT_W-1:0] d, input bit kept);
        c_in    = c;
        c_valid = 1'b1;
        if (kept) expect_push(d);
        @(posedge clk);
        #1;
        c_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(posedge clk);
        #1;
        check(tag, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every handshake against the scoreboard head.
    always @(negedge clk) begin
        if (rstn && valid && ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_underflow", exp_q.size(), 1);
            end else begin
                check("sb_data", data, exp_q[0].d);
                check("sb_last", last, exp_q[0].l);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        rstn    = 1'b0;
        c_in    = '0;
        c_valid = 1'b0;
        shift   = '0;
        clr_err = 1'b0;
        ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data",  data,  0);
        check("rst_last",  last,  0);
        check("rst_ovf",   ovf,   0);
        check("rst_drop",  drop,  0);
        check("rst_stall", stall, 0);
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        ready = 1'b1;

        // Rounding, with explicit two-cycle latency check on the first element.
        shift   = 4'd4;
        c_in    = 16'h0138;
        c_valid = 1'b1;
        expect_push(8'h14);
        @(negedge clk);
        check("lat_t0", valid, 0);
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        @(negedge clk);
        check("lat_t1", valid, 0);
        @(negedge clk);
        check("lat_t2", valid, 1);
        @(posedge clk);
        #1;
        send(16'hFFE8, 8'hFF, 1);
        drain("drain_round");
        check("round_ovf", ovf, 0);

        // Saturation both ways, then clear.
        shift = 4'd0;
        send(16'h7FFF, 8'h7F, 1);
        send(16'hFED4, 8'h80, 1);
        drain("drain_sat");
        check("sat_ovf", ovf, 1);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_ovf", ovf, 0);

        // Largest positive input with the largest shift must not wrap.
        shift = 4'd15;
        send(16'h7FFF, 8'h01, 1);
        drain("drain_wrap");
        check("wrap_ovf", ovf, 0);

        // Column framing from a fresh index: nine back-to-back inputs.
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn  = 1'b1;
        idx_m = 0;
        shift = 4'd2;
        pop_cyc.delete();
        s0 = cyc;
        for (int i = 0; i < 9; i++) begin
            logic [OC_W-1:0] v;
            v = OC_W'($urandom_range(0, 2000)) - OC_W'(1000);
            send(v, model(v, 2), 1);
        end
        drain("drain_frame");
        check("frame_pops", pop_cyc.size(), 9);
        if (pop_cyc.size() == 9) begin
            check("frame_first", pop_cyc[0] - s0, 2);
            check("frame_span",  pop_cyc[8] - pop_cyc[0], 8);
        end

        // Backpressure: fill stage + FIFO, drop the sixth input.
        shift = 4'd0;
        ready = 1'b0;
        send(16'd1, 8'd1, 1);
        send(16'd2, 8'd2, 1);
        check("bp_stall_2", stall, 0);
        send(16'd3, 8'd3, 1);
        check("bp_stall_3", stall, 1);
        send(16'd4, 8'd4, 1);
        send(16'd5, 8'd5, 1);
        check("bp_drop_pre", drop, 0);
        send(16'd99, 8'd0, 0);
        check("bp_drop", drop, 1);
        check("bp_hold_valid", valid, 1);
        check("bp_hold_data", data, exp_q[0].d);
        pop_cyc.delete();
        ready = 1'b1;
        drain("drain_bp");
        check("bp_pops", pop_cyc.size(), 5);
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        check("clr_drop", drop, 0);

        // Reset mid-stream discards buffered data and restarts the index.
        ready = 1'b0;
        send(16'd10, 8'd10, 1);
        send(16'd11, 8'd11, 1);
        send(16'd12, 8'd12, 1);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        idx_m = 0;
        check("mrst_valid", valid, 0);
        check("mrst_stall", stall, 0);
        ready = 1'b1;
        pop_cyc.delete();
        s0 = cyc;
        for (int i = 0; i < Y; i++) begin
            logic [OC_W-1:0] v;
            v = OC_W'(i * 37);
            send(v, model(v, 0), 1);
        end
        drain("drain_mrst");
        check("mrst_pops", pop_cyc.size(), Y);
        if (pop_cyc.size() > 0) check("mrst_lat", pop_cyc[0] - s0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
